pl_mem_arbiter: RTL and testbench
=================================

Name: pl_mem_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the pipelined RV32I CPU's IF stage and MEM stage (load/store). It sequences each access through a fixed-latency memory and returns per-requester ready pulses, which the pipeline uses as stall/advance conditions. MEM stage has priority, with a starvation guard for IF. A branch/jump redirect can discard an in-flight fetch.

Parameters:
AW, 32, byte-address width.
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1).
MAX_DM_BURST, 4, consecutive DM grants allowed while if_req is pending before IF is forced.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, synchronous, active-high (name kept for consistency).
if_req  in  1  fetch request; held until if_ready or if_flush.
if_addr  in  AW  fetch byte address.
if_flush  in  1  one-cycle redirect pulse; discards pending/in-flight fetch.
if_rdata  out  32  fetched instruction.
if_ready  out  1  one-cycle pulse: if_rdata valid.
dm_req  in  1  load/store request; held until dm_ready.
dm_we  in  1  1 = store.
dm_be  in  4  store byte enables.
dm_addr  in  AW  data byte address.
dm_wdata  in  32  store data.
dm_rdata  out  32  load data.
dm_ready  out  1  one-cycle pulse: access complete.
mem_en  out  1  memory access strobe, one cycle per access.
mem_we  out  1  memory write.
mem_be  out  4  memory byte enables.
mem_addr  out  AW  memory byte address (word aligned, [1:0] forced 0).
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (rstn=1 at edge): state IDLE, all outputs 0, burst counter 0, latency counter 0, drop flag 0, owner = none. Mid-access reset abandons the access; late mem_rdata ignored; no ready pulse.
- States: IDLE, ISSUE, WAIT, DONE. All outputs registered.
- IDLE: sample requests. Grant DM if dm_req and not (if_req and burst==MAX_DM_BURST); else grant IF if if_req and not if_flush; else stay. Latch owner, addr, we, be, wdata -> ISSUE.
- ISSUE: mem_en=1 for exactly one cycle with latched fields (IF grant: mem_we=0, mem_be=4'hF). -> WAIT.
- WAIT: count MEM_LAT-1 further cycles; on the cycle mem_rdata is valid (cycle ISSUE+MEM_LAT) capture it into owner's rdata register; -> DONE. For MEM_LAT=1, WAIT lasts 1 cycle.
- DONE: owner's ready=1 for one cycle (suppressed if drop flag set); requests not sampled in DONE (prevents re-issuing the held request); -> IDLE.
- Timing (request visible in cycle 0, arbiter IDLE): mem_en cycle 1, ready cycle MEM_LAT+2, next grant sampled cycle MEM_LAT+3. Throughput: one access per MEM_LAT+3 cycles.
- Store: dm_rdata = 0 on completion; dm_ready still pulses.
- Burst counter: incremented on DM grant while if_req=1; cleared on IF grant or when if_req=0 in IDLE; saturates at MAX_DM_BURST.
- if_flush: in IDLE, blocks IF grant that cycle. In ISSUE/WAIT/DONE with owner IF, sets drop flag; access completes to memory but if_ready stays 0 and if_rdata unchanged. Ignored when owner is DM. Drop flag cleared on entering IDLE.
- Simultaneous if_req and dm_req in IDLE: DM wins unless guard active.
- Addresses: mem_addr = {addr[AW-1:2], 2'b00}; no misalignment error reporting.

Decomposition:
- Shared package pl_mem_pkg: state encoding (IDLE/ISSUE/WAIT/DONE), owner encoding (NONE/IF/DM), BE_WORD=4'hF.
- No sub-module; single FSM plus latency and burst counters.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0000_0004 at cycle 0, memory returns 0x0010_0093 -> mem_en cycle 1 with mem_addr=0x4, if_ready=1 and if_rdata=0x0010_0093 in cycle 4 only.
- Contention: if_req and dm_req (load 0x100, data 0xDEADBEEF) both at cycle 0 -> DM served first (dm_ready cycle 4), IF mem_en cycle 6, if_ready cycle 9.
- Store: dm_we=1, dm_be=4'b0011, dm_addr=0x203, dm_wdata=0x1234_5678 -> mem_we=1, mem_be=4'b0011, mem_addr=0x200, mem_wdata=0x1234_5678 at cycle 1; dm_ready cycle 4, dm_rdata=0.
- Starvation guard: dm_req held continuously for 6 accesses with if_req=1 -> grants DM,DM,DM,DM,IF,DM; burst counter resets after IF grant.
- Flush: fetch issued, if_flush pulsed in WAIT cycle -> mem_en still occurs once, if_ready never asserts, FSM in IDLE at cycle 5.
- Reset mid-access: rstn=1 during WAIT -> next cycle all outputs 0, state IDLE, no ready pulse; new fetch after release completes in MEM_LAT+2 cycles.

Source files
------------

// File: rtl/pl_mem_pkg.sv
// Shared encodings for the IF/MEM memory arbiter: FSM states, access owner,
// and the full-word byte-enable used for instruction fetches.
package pl_mem_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/pl_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch
// and load/store. DM has priority; a burst guard keeps IF from starving.
module pl_mem_arbiter
  import pl_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int MEM_LAT      = 2,
  parameter int MAX_DM_BURST = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BW = $clog2(MAX_DM_BURST + 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LAT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DM_BURST);

  logic [1:0]    state;
  logic [1:0]    owner;
  logic          drop;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] burst;

  logic guard, grant_dm, grant_if, flush_own;

  always_comb begin
    guard     = if_req && (burst == BURST_MAX);
    grant_dm  = dm_req && !guard;
    grant_if  = !grant_dm && if_req && !if_flush;
    flush_own = if_flush && (owner == OWN_IF);
  end

  // The latched request lives directly in the registered mem_* outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= S_IDLE;
      owner     <= OWN_NONE;
      drop      <= 1'b0;
      lat_cnt   <= '0;
      burst     <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (grant_dm) begin
            state     <= S_ISSUE;
            owner     <= OWN_DM;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= {dm_addr[AW-1:2], 2'b00};
            mem_wdata <= dm_wdata;
            if (!if_req)
              burst <= '0;
            else if (burst != BURST_MAX)
              burst <= burst + BW'(1);
          end else if (grant_if) begin
            state     <= S_ISSUE;
            owner     <= OWN_IF;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= BE_WORD;
            mem_addr  <= {if_addr[AW-1:2], 2'b00};
            mem_wdata <= '0;
            burst     <= '0;
          end else if (!if_req) begin
            burst <= '0;
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          lat_cnt <= '0;
          if (flush_own) drop <= 1'b1;
        end
        S_WAIT: begin
          if (flush_own) drop <= 1'b1;
          if (lat_cnt == LAT_LAST) begin
            state <= S_DONE;
            // A redirect landing on the capture cycle must also kill the fetch.
            if (owner == OWN_DM) begin
              dm_rdata <= mem_we ? 32'h0 : mem_rdata;
              dm_ready <= 1'b1;
            end else if (!(drop || flush_own)) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
          drop  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Bench for pl_mem_arbiter: table of single accesses plus hand-built contention,
// starvation, flush and reset sequences, checked through expectation queues.
module tb_pl_mem_arbiter;

  localparam int AW = 32, LAT = 2, MAXB = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req, if_flush, if_ready;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we, dm_ready;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  pl_mem_arbiter #(.AW(AW), .MEM_LAT(LAT), .MAX_DM_BURST(MAXB)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: fixed-latency read pipe, byte-enabled writes, preset contents.
  logic [31:0] memw [1024];
  bit          wv   [1024];
  logic [31:0] rpipe [LAT];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h004: return 32'h0010_0093;
      32'h008: return 32'h0020_8113;
      32'h100: return 32'hDEAD_BEEF;
      32'h200: return 32'hAAAA_AAAA;
      32'h300: return 32'h0000_0000;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return wv[a[11:2]] ? memw[a[11:2]] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 32'hBAD0_BAD0;
    if (mem_en && mem_we) begin
      memw[mem_addr[11:2]] <= merge(rd(mem_addr), mem_wdata, mem_be);
      wv[mem_addr[11:2]]   <= 1'b1;
    end
  end
  assign mem_rdata = rpipe[LAT-1];

  // Scoreboards
  typedef struct {int c; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wd;} mexp_t;
  typedef struct {int c; bit dm; logic [31:0] data;} rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];

  task automatic exp_mem(input int c, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    mexp_t e;
    e.c = c; e.we = we; e.be = be; e.addr = addr; e.wd = wd;
    mq.push_back(e);
  endtask

  task automatic exp_rsp(input int c, input bit dm, input logic [31:0] d);
    rexp_t r;
    r.c = c; r.dm = dm; r.data = d;
    rq.push_back(r);
  endtask

  task automatic take_rsp(input bit dm, input logic [31:0] d);
    rexp_t r;
    if (rq.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_ready: dm=%0d data %0h at cycle %0d, none required", dm, d, cyc);
    end else begin
      r = rq.pop_front();
      chk("rsp_cycle", 64'(cyc), 64'(r.c));
      chk("rsp_owner", 64'(dm), 64'(r.dm));
      chk("rsp_data", 64'(d), 64'(r.data));
    end
  endtask

  always @(negedge clk) begin
    mexp_t e;
    if (!rstn) begin
      if (mem_en) begin
        if (mq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_en: addr %0h at cycle %0d, none required", mem_addr, cyc);
        end else begin
          e = mq.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(e.c));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_be", 64'(mem_be), 64'(e.be));
          if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
        end
      end
      if (if_ready) take_rsp(1'b0, if_rdata);
      if (dm_ready) take_rsp(1'b1, dm_rdata);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [63:0] outs();
    return {if_ready, dm_ready, mem_en, mem_we, mem_be} |
           {32'h0, if_rdata | dm_rdata | mem_addr | mem_wdata};
  endfunction

  typedef struct {
    bit dm; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] e_maddr; logic [3:0] e_be; logic [31:0] e_data;
  } vec_t;
  vec_t vt [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vt[0] = '{1'b0, 1'b0, 4'hF, 32'h004, 32'h0,         32'h004, 4'hF, 32'h0010_0093};
    vt[1] = '{1'b1, 1'b0, 4'hF, 32'h100, 32'h0,         32'h100, 4'hF, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b1, 4'h3, 32'h203, 32'h1234_5678, 32'h200, 4'h3, 32'h0};
    vt[3] = '{1'b1, 1'b0, 4'hF, 32'h200, 32'h0,         32'h200, 4'hF, 32'hAAAA_5678};
    vt[4] = '{1'b0, 1'b0, 4'hF, 32'h102, 32'h0,         32'h100, 4'hF, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 1'b1, 4'hC, 32'h300, 32'hCAFE_F00D, 32'h300, 4'hC, 32'h0};
    vt[6] = '{1'b1, 1'b0, 4'hF, 32'h301, 32'h0,         32'h300, 4'hF, 32'hCAFE_0000};

    rstn = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) tick();
    chk("reset_outputs", outs(), 64'h0);
    rstn = 1'b0;
    tick();

    // Single accesses back to back at full throughput
    foreach (vt[i]) begin
      t0 = cyc;
      if (vt[i].dm) begin
        dm_req = 1; dm_we = vt[i].we; dm_be = vt[i].be;
        dm_addr = vt[i].addr; dm_wdata = vt[i].wdata;
      end else begin
        if_req = 1; if_addr = vt[i].addr;
      end
      exp_mem(t0 + 1, vt[i].we, vt[i].e_be, vt[i].e_maddr, vt[i].wdata);
      exp_rsp(t0 + LAT + 2, vt[i].dm, vt[i].e_data);
      at(t0 + LAT + 2);
      dm_req = 0; if_req = 0; dm_we = 0;
      at(t0 + LAT + 3);
    end

    // Contention: DM first, IF next slot
    t0 = cyc;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h100;
    if_req = 1; if_addr = 32'h004;
    exp_mem(t0 + 1, 1'b0, 4'hF, 32'h100, 32'h0);
    exp_rsp(t0 + 4, 1'b1, 32'hDEAD_BEEF);
    exp_mem(t0 + 6, 1'b0, 4'hF, 32'h004, 32'h0);
    exp_rsp(t0 + 9, 1'b0, 32'h0010_0093);
    at(t0 + 4); dm_req = 0;
    at(t0 + 9); if_req = 0;
    at(t0 + 10);

    // Starvation guard: DM x4, IF, DM (burst restarted), then IF
    t0 = cyc;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h100;
    if_req = 1; if_addr = 32'h004;
    for (int k = 0; k < 4; k++) begin
      exp_mem(t0 + 1 + 5*k, 1'b0, 4'hF, 32'h100, 32'h0);
      exp_rsp(t0 + 4 + 5*k, 1'b1, 32'hDEAD_BEEF);
    end
    exp_mem(t0 + 21, 1'b0, 4'hF, 32'h004, 32'h0);
    exp_rsp(t0 + 24, 1'b0, 32'h0010_0093);
    exp_mem(t0 + 26, 1'b0, 4'hF, 32'h100, 32'h0);
    exp_rsp(t0 + 29, 1'b1, 32'hDEAD_BEEF);
    exp_mem(t0 + 31, 1'b0, 4'hF, 32'h004, 32'h0);
    exp_rsp(t0 + 34, 1'b0, 32'h0010_0093);
    at(t0 + 29); dm_req = 0;
    at(t0 + 34); if_req = 0;
    at(t0 + 35);

    // Flush during WAIT drops the fetch; flush in IDLE delays the next grant
    t0 = cyc;
    if_req = 1; if_addr = 32'h100C;
    exp_mem(t0 + 1, 1'b0, 4'hF, 32'h100C, 32'h0);
    at(t0 + 2); if_flush = 1;
    at(t0 + 3); if_flush = 0; if_req = 0;
    at(t0 + 5);
    chk("flush_if_rdata_kept", 64'(if_rdata), 64'h0010_0093);
    if_req = 1; if_addr = 32'h008; if_flush = 1;
    exp_mem(t0 + 7, 1'b0, 4'hF, 32'h008, 32'h0);
    exp_rsp(t0 + 10, 1'b0, 32'h0020_8113);
    at(t0 + 6); if_flush = 0;
    at(t0 + 10); if_req = 0;
    at(t0 + 11);

    // Reset in WAIT abandons the fetch; a new fetch then completes normally
    t0 = cyc;
    if_req = 1; if_addr = 32'h004;
    exp_mem(t0 + 1, 1'b0, 4'hF, 32'h004, 32'h0);
    at(t0 + 2); rstn = 1'b1; if_req = 0;
    at(t0 + 3);
    chk("midreset_outputs", outs(), 64'h0);
    rstn = 1'b0;
    at(t0 + 4);
    if_req = 1; if_addr = 32'h200;
    exp_mem(t0 + 5, 1'b0, 4'hF, 32'h200, 32'h0);
    exp_rsp(t0 + 8, 1'b0, 32'hAAAA_5678);
    at(t0 + 8); if_req = 0;
    at(t0 + 9);

    repeat (8) tick();
    chk("mem_queue_drained", 64'(mq.size()), 64'h0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
